// File: rtl/ym2149_vgm_seq.sv
// VGM command sequencer feeding the ym2149 PSG register bus.
// Decodes AY-3-8910 write (0xA0) and wait (0x61/0x62/0x63/0x7n) commands, stops on 0x66 or an unknown opcode.
module ym2149_vgm_seq #(
  parameter int unsigned SAMPLE_DIV = 567,
  parameter int unsigned DIV_W      = 10
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [3:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_OPCODE = 4'd1,
    S_ARG1   = 4'd2,
    S_ARG2   = 4'd3,
    S_WRITE  = 4'd4,
    S_WR_GAP = 4'd5,
    S_WAIT   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  state_t           state_q, state_d;
  logic             kind_wait_q, kind_wait_d;
  logic [7:0]       arg1_q, arg1_d;
  logic [15:0]      count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       reg_q, reg_d;
  logic [7:0]       val_q, val_d;
  logic             wr_q, wr_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             take;

  // Handshake: a byte moves on a rising edge where in_valid && out_ready; out_ready
  // is a registered decode of OPCODE/ARG1/ARG2, and nothing is buffered.
  assign take = in_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    kind_wait_d = kind_wait_q;
    arg1_d      = arg1_q;
    count_d     = count_q;
    div_d       = div_q;
    reg_d       = reg_q;
    val_d       = val_q;

    case (state_q)
      S_IDLE: begin
        if (in_start) state_d = S_OPCODE;
      end
      S_OPCODE: begin
        if (take) begin
          div_d = '0;
          casez (in_data)
            8'hA0: begin kind_wait_d = 1'b0; state_d = S_ARG1; end
            8'h61: begin kind_wait_d = 1'b1; state_d = S_ARG1; end
            8'h62: begin count_d = 16'd735; state_d = S_WAIT; end
            8'h63: begin count_d = 16'd882; state_d = S_WAIT; end
            8'b0111_????: begin
              count_d = {12'd0, in_data[3:0]} + 16'd1;
              state_d = S_WAIT;
            end
            8'h66:   state_d = S_DONE;
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_ARG1: begin
        if (take) begin
          arg1_d  = in_data;
          state_d = S_ARG2;
        end
      end
      S_ARG2: begin
        if (take) begin
          if (kind_wait_q) begin
            count_d = {in_data, arg1_q};
            div_d   = '0;
            state_d = S_WAIT;
          end else if (arg1_q[7:4] == 4'd0) begin
            reg_d   = arg1_q[3:0];
            val_d   = in_data;
            state_d = S_WRITE;
          end else begin
            // Second-chip or out-of-range register: swallow the command silently.
            state_d = S_OPCODE;
          end
        end
      end
      S_WRITE:  state_d = S_WR_GAP;
      S_WR_GAP: state_d = S_OPCODE;
      S_WAIT: begin
        if (count_q == 16'd0) begin
          div_d   = '0;
          state_d = S_OPCODE;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          count_d = count_q - 16'd1;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_DONE, S_ERROR: begin
        if (in_start) state_d = S_OPCODE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_d    = (state_d == S_WRITE);
    ready_d = (state_d == S_OPCODE) || (state_d == S_ARG1) || (state_d == S_ARG2);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      kind_wait_q <= 1'b0;
      arg1_q      <= '0;
      count_q     <= '0;
      div_q       <= '0;
      reg_q       <= '0;
      val_q       <= '0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_wait_q <= kind_wait_d;
      arg1_q      <= arg1_d;
      count_q     <= count_d;
      div_q       <= div_d;
      reg_q       <= reg_d;
      val_q       <= val_d;
      wr_q        <= wr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign out_ready = ready_q;
  assign out_reg   = reg_q;
  assign out_val   = val_q;
  assign out_wr    = wr_q;
  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_error = error_q;

endmodule

// File: tb/tb_ym2149_vgm_seq.sv
// Bench for ym2149_vgm_seq: scenario tasks with a command-level model of expected writes and wait lengths.
// A short prescaler keeps long waits affordable.
module tb_ym2149_vgm_seq;

  localparam int DIV = 4;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       in_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_busy;
  logic       out_done;
  logic       out_error;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  int          wr_double = 0;
  int          gap_bad = 0;
  logic        prev_wr = 1'b0;
  logic [11:0] last_wr = '0;

  ym2149_vgm_seq #(.SAMPLE_DIV(DIV), .DIV_W(10)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_start (in_start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_error(out_error)
  );

  // clock / reset
  always #5 in_clk = ~in_clk;

  task automatic do_reset();
    in_rst_n = 1'b0;
    in_start = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge in_clk);
    in_rst_n = 1'b1;
    @(negedge in_clk);
  endtask

  // write-bus monitor: records every strobe and checks strobe width / hold
  always @(negedge in_clk) begin
    cyc++;
    if (out_wr === 1'b1) begin
      if (prev_wr) wr_double++;
      obs_q.push_back({out_reg, out_val});
      wr_cyc_q.push_back(cyc);
      last_wr = {out_reg, out_val};
    end else if (prev_wr && ({out_reg, out_val} !== last_wr)) begin
      gap_bad++;
    end
    prev_wr = (out_wr === 1'b1);
  end

  // drivers
  task automatic pulse_start();
    @(negedge in_clk);
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    @(negedge in_clk);
    in_valid = 1'b0;
    repeat (stall) @(negedge in_clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (out_ready !== 1'b1 && n < 20000) begin
      @(negedge in_clk);
      n++;
    end
    if (n >= 20000) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout byte=%02h: out_ready never rose", b);
    end
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    wr_cyc_q.delete();
    wr_double = 0;
    gap_bad   = 0;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_vec++; if (out_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", out_ready); end
    n_vec++; if (out_reg !== 4'd0) begin n_err++; $display("FAIL reset_reg got=%0d exp=0", out_reg); end
    n_vec++; if (out_val !== 8'd0) begin n_err++; $display("FAIL reset_val got=%02h exp=00", out_val); end
    n_vec++; if (out_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b exp=0", out_wr); end
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    n_vec++; if (out_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", out_done); end
    n_vec++; if (out_error !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b exp=0", out_error); end
  endtask

  task automatic test_single_write();
    clear_sb();
    pulse_start();
    n_vec++; if (out_ready !== 1'b1 || out_busy !== 1'b1) begin
      n_err++; $display("FAIL start_ready got ready=%b busy=%b exp 1 1", out_ready, out_busy);
    end
    send_byte(8'hA0, 0);
    send_byte(8'h07, 0);
    send_byte(8'h38, 0);
    @(negedge in_clk);
    n_vec++; if (out_wr !== 1'b1 || out_reg !== 4'd7 || out_val !== 8'h38 || out_ready !== 1'b0) begin
      n_err++; $display("FAIL write_pulse got wr=%b reg=%0d val=%02h rdy=%b exp 1 7 38 0", out_wr, out_reg, out_val, out_ready);
    end
    @(negedge in_clk);
    n_vec++; if (out_wr !== 1'b0 || out_reg !== 4'd7 || out_val !== 8'h38) begin
      n_err++; $display("FAIL write_gap got wr=%b reg=%0d val=%02h exp 0 7 38", out_wr, out_reg, out_val);
    end
    @(negedge in_clk);
    n_vec++; if (out_ready !== 1'b1) begin n_err++; $display("FAIL write_return got ready=%b exp=1", out_ready); end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    exp_q.push_back({4'd8, 8'h0F});
    exp_q.push_back({4'd9, 8'h0C});
    send_byte(8'hA0, 0); send_byte(8'h08, 0); send_byte(8'h0F, 0);
    send_byte(8'hA0, 0); send_byte(8'h09, 0); send_byte(8'h0C, 0);
    repeat (4) @(negedge in_clk);
    n_vec++; if (obs_q.size() != 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d] got=%03h exp=%03h", i, obs_q[i], exp_q[i]); end
    end
    if (wr_cyc_q.size() == 2) begin
      n_vec++; if (wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
        n_err++; $display("FAIL b2b_spacing got=%0d exp=5", wr_cyc_q[1] - wr_cyc_q[0]);
      end
    end
    n_vec++; if (wr_double != 0 || gap_bad != 0) begin
      n_err++; $display("FAIL b2b_strobe got double=%0d gap_bad=%0d exp 0 0", wr_double, gap_bad);
    end
  endtask

  task automatic test_second_chip();
    clear_sb();
    send_byte(8'hA0, 0); send_byte(8'h88, 0); send_byte(8'h55, 0);
    send_byte(8'hA0, 1); send_byte(8'h12, 0); send_byte(8'h55, 2);
    exp_q.push_back({4'd3, 8'h77});
    send_byte(8'hA0, 0); send_byte(8'h03, 0); send_byte(8'h77, 0);
    repeat (4) @(negedge in_clk);
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL chip2_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_vec++; if (obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL chip2_data got=%03h exp=%03h", obs_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_waits();
    logic [7:0] b0, b1, b2;
    int nbytes, samples, cnt;
    for (int j = 0; j < 6; j++) begin
      b1 = 8'h00; b2 = 8'h00;
      case (j)
        0: begin b0 = 8'h75; nbytes = 1; samples = 6; end
        1: begin b0 = 8'h62; nbytes = 1; samples = 735; end
        2: begin b0 = 8'h61; nbytes = 3; samples = 0; end
        3: begin b0 = 8'h63; nbytes = 1; samples = 882; end
        4: begin
          b0 = 8'h70 | 8'($urandom_range(0, 15)); nbytes = 1; samples = 1 + int'(b0 & 8'h0F);
        end
        default: begin
          samples = $urandom_range(1, 400); b0 = 8'h61; nbytes = 3;
          b1 = 8'(samples); b2 = 8'(samples >> 8);
        end
      endcase
      send_byte(b0, 0);
      if (nbytes == 3) begin send_byte(b1, 0); send_byte(b2, 0); end
      cnt = 0;
      @(negedge in_clk);
      while (out_ready !== 1'b1 && cnt < 10000) begin
        n_vec++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL wait_busy op=%02h got=%b exp=1", b0, out_busy); end
        cnt++;
        @(negedge in_clk);
      end
      n_vec++; if (cnt != samples * DIV + 1) begin
        n_err++; $display("FAIL wait_len op=%02h got=%0d exp=%0d", b0, cnt, samples * DIV + 1);
      end
    end
  endtask

  task automatic test_done();
    int cnt;
    send_byte(8'h61, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    cnt = 0;
    @(negedge in_clk);
    while (out_ready !== 1'b1 && cnt < 1000) begin cnt++; @(negedge in_clk); end
    n_vec++; if (cnt != 3 * DIV + 1) begin n_err++; $display("FAIL done_wait got=%0d exp=%0d", cnt, 3 * DIV + 1); end
    send_byte(8'h66, 0);
    @(negedge in_clk);
    n_vec++; if (out_done !== 1'b1 || out_busy !== 1'b0 || out_ready !== 1'b0 || out_error !== 1'b0) begin
      n_err++; $display("FAIL done_flags got done=%b busy=%b rdy=%b err=%b exp 1 0 0 0", out_done, out_busy, out_ready, out_error);
    end
    repeat (5) @(negedge in_clk);
    n_vec++; if (out_done !== 1'b1) begin n_err++; $display("FAIL done_sticky got=%b exp=1", out_done); end
    pulse_start();
    n_vec++; if (out_done !== 1'b0 || out_ready !== 1'b1) begin
      n_err++; $display("FAIL done_restart got done=%b rdy=%b exp 0 1", out_done, out_ready);
    end
  endtask

  task automatic test_error();
    logic [7:0] bad;
    for (int j = 0; j < 3; j++) begin
      if (j == 0) bad = 8'h4F;
      else begin
        do bad = 8'($urandom);
        while (bad == 8'hA0 || bad == 8'h61 || bad == 8'h62 || bad == 8'h63 || bad == 8'h66 || bad[7:4] == 4'h7);
      end
      send_byte(bad, 0);
      @(negedge in_clk);
      n_vec++; if (out_error !== 1'b1 || out_ready !== 1'b0 || out_busy !== 1'b0) begin
        n_err++; $display("FAIL error_flags op=%02h got err=%b rdy=%b busy=%b exp 1 0 0", bad, out_error, out_ready, out_busy);
      end
      in_start = 1'b0;
      repeat (3) @(negedge in_clk);
      n_vec++; if (out_error !== 1'b1) begin n_err++; $display("FAIL error_sticky got=%b exp=1", out_error); end
      pulse_start();
      n_vec++; if (out_error !== 1'b0 || out_ready !== 1'b1) begin
        n_err++; $display("FAIL error_clear got err=%b rdy=%b exp 0 1", out_error, out_ready);
      end
    end
  endtask

  task automatic test_random_stream();
    int k, r, v, w;
    clear_sb();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      case (k)
        0, 1: begin
          r = $urandom_range(0, 15); v = $urandom_range(0, 255);
          exp_q.push_back({4'(r), 8'(v)});
          send_byte(8'hA0, $urandom_range(0, 2));
          send_byte(8'(r), $urandom_range(0, 2));
          send_byte(8'(v), $urandom_range(0, 2));
        end
        2: begin
          r = ($urandom_range(0, 1) == 1) ? (128 + $urandom_range(0, 127)) : $urandom_range(16, 127);
          send_byte(8'hA0, 0); send_byte(8'(r), $urandom_range(0, 2)); send_byte(8'($urandom), 0);
        end
        3: send_byte(8'h70 | 8'($urandom_range(0, 15)), $urandom_range(0, 2));
        default: begin
          w = $urandom_range(0, 20);
          send_byte(8'h61, 0); send_byte(8'(w), $urandom_range(0, 2)); send_byte(8'h00, 0);
        end
      endcase
    end
    send_byte(8'h66, 0);
    repeat (3) @(negedge in_clk);
    n_vec++; if (out_done !== 1'b1) begin n_err++; $display("FAIL rand_done got=%b exp=1", out_done); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d] got=%03h exp=%03h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (wr_double != 0 || gap_bad != 0) begin
      n_err++; $display("FAIL rand_strobe got double=%0d gap_bad=%0d exp 0 0", wr_double, gap_bad);
    end
    pulse_start();
  endtask

  task automatic test_reset_mid_wait();
    int cnt;
    send_byte(8'hA0, 0); send_byte(8'h05, 0); send_byte(8'hAA, 0);
    send_byte(8'h7F, 0);
    repeat (10) @(negedge in_clk);
    n_vec++; if (out_busy !== 1'b1 || out_val !== 8'hAA) begin
      n_err++; $display("FAIL pre_reset got busy=%b val=%02h exp 1 AA", out_busy, out_val);
    end
    #2 in_rst_n = 1'b0;
    #1;
    n_vec++; if ({out_ready, out_reg, out_val, out_wr, out_busy, out_done, out_error} !== 17'd0) begin
      n_err++; $display("FAIL async_reset got rdy=%b reg=%0d val=%02h wr=%b busy=%b done=%b err=%b exp all 0",
                        out_ready, out_reg, out_val, out_wr, out_busy, out_done, out_error);
    end
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    repeat (5) @(negedge in_clk);
    n_vec++; if (out_ready !== 1'b0 || out_busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle got rdy=%b busy=%b exp 0 0", out_ready, out_busy);
    end
    pulse_start();
    send_byte(8'h70, 0);
    cnt = 0;
    @(negedge in_clk);
    while (out_ready !== 1'b1 && cnt < 1000) begin cnt++; @(negedge in_clk); end
    n_vec++; if (cnt != DIV + 1) begin n_err++; $display("FAIL post_reset_wait got=%0d exp=%0d", cnt, DIV + 1); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_second_chip();
    test_waits();
    test_done();
    test_error();
    test_random_stream();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
